// File: rtl/wb_counter_bank.sv
// wb_counter_bank: Wishbone-mapped bank of CHANNELS programmable WIDTH-bit counters/timers.
// Define COUNTER_BANK_PRESCALER_EN to add the shared 8-bit step prescaler at 0xF0.
module wb_counter_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_cyc,
    input  logic                      wb_stb,
    input  logic                      wb_we,
    input  logic [3:0]                wb_sel,
    input  logic [7:0]                wb_adr,
    input  logic [31:0]               wb_dat_i,
    output logic                      wb_ack,
    output logic [31:0]               wb_dat_o,
    input  logic [CHANNELS-1:0]       la_load,
    input  logic [WIDTH-1:0]          la_data,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic                      irq
);
    logic access, tick;
    logic [31:0] mask, rdata, glob;
    logic [3:0] ch;
    logic [15:0] en_a, down_a, per_a, ien_a, match_a, irq_v;
    logic [WIDTH-1:0] cnt_a [16];
    logic [WIDTH-1:0] rld_a [16];
    logic unused_adr;

    assign access = wb_cyc & wb_stb & ~wb_ack;
    assign mask = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
    assign ch = wb_adr[7:4];
    assign unused_adr = ^wb_adr[1:0];

`ifdef COUNTER_BANK_PRESCALER_EN
    logic [7:0] presc, div;
    logic wr_presc;
    assign wr_presc = access & wb_we & (wb_adr[7:2] == 6'h3C);
    assign tick = div == presc;
    assign glob = 32'(presc);
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            div   <= '0;
        end else begin
            if (wr_presc & wb_sel[0]) presc <= wb_dat_i[7:0];
            div <= (wr_presc | tick) ? 8'd0 : div + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
    assign glob = '0;
`endif

    for (genvar g = 0; g < 16; g++) begin : g_ch
        if (g < CHANNELS) begin : g_on
            logic [WIDTH-1:0] cnt, rld, cnt_n;
            logic [3:0] ctrl, ctrl_n;
            logic match, match_n, wr, wr_cnt, step, hit;
            assign wr = access & wb_we & (wb_adr[7:4] == 4'(g));
            assign wr_cnt = wr & (wb_adr[3:2] == 2'd1);
            // COUNT writes and LA loads pre-empt the step, match detection included
            assign step = ctrl[0] & tick & ~wr_cnt & ~la_load[g];
            assign hit = ctrl[1] ? cnt == '0 : cnt == rld;
            assign cnt_n = wr_cnt ? WIDTH'((32'(cnt) & ~mask) | (wb_dat_i & mask))
                         : la_load[g] ? la_data
                         : !step ? cnt
                         : !hit ? (ctrl[1] ? cnt - WIDTH'(1) : cnt + WIDTH'(1))
                         : !ctrl[2] ? cnt
                         : ctrl[1] ? rld : '0;
            assign ctrl_n = (wr & wb_adr[3:2] == 2'd0) ? 4'((32'(ctrl) & ~mask) | (wb_dat_i & mask))
                          : (step & hit & ~ctrl[2]) ? {ctrl[3:1], 1'b0} : ctrl;
            assign match_n = (step & hit) | (match & ~(wr & wb_adr[3:2] == 2'd3 & wb_sel[0] & wb_dat_i[0]));
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt   <= '0;
                    rld   <= '0;
                    ctrl  <= '0;
                    match <= 1'b0;
                end else begin
                    cnt   <= cnt_n;
                    ctrl  <= ctrl_n;
                    match <= match_n;
                    if (wr & wb_adr[3:2] == 2'd2) rld <= WIDTH'((32'(rld) & ~mask) | (wb_dat_i & mask));
                end
            end
            assign {ien_a[g], per_a[g], down_a[g], en_a[g]} = ctrl;
            assign match_a[g] = match;
            assign cnt_a[g] = cnt;
            assign rld_a[g] = rld;
            assign irq_v[g] = match_n & ctrl_n[3];
            assign count[g*WIDTH +: WIDTH] = cnt;
        end else begin : g_off
            assign {ien_a[g], per_a[g], down_a[g], en_a[g]} = 4'd0;
            assign match_a[g] = 1'b0;
            assign cnt_a[g] = '0;
            assign rld_a[g] = '0;
            assign irq_v[g] = 1'b0;
        end
    end

    // Unmapped channels are tied to zero above, so only 0xF0 needs special handling
    assign rdata = wb_adr[3:2] == 2'd0 ? (ch == 4'hF ? glob : 32'({ien_a[ch], per_a[ch], down_a[ch], en_a[ch]}))
                 : wb_adr[3:2] == 2'd1 ? 32'(cnt_a[ch])
                 : wb_adr[3:2] == 2'd2 ? 32'(rld_a[ch])
                 : 32'(match_a[ch]);

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack   <= 1'b0;
            wb_dat_o <= '0;
            irq      <= 1'b0;
        end else begin
            wb_ack <= access;
            if (access & ~wb_we) wb_dat_o <= rdata;
            irq <= |irq_v;
        end
    end
endmodule

// File: tb/tb_wb_counter_bank.sv
// tb_wb_counter_bank: directed plus randomized Wishbone/LA stimulus, scoreboarded
// against a behavioural model of the counter bank (honours COUNTER_BANK_PRESCALER_EN).
module tb_wb_counter_bank;
    localparam int W = 16;
    localparam int CH = 4;
    localparam int unsigned MASK = (1 << W) - 1;

    logic clk = 0, reset = 1;
    logic cyc = 0, stb = 0, we = 0;
    logic [3:0] sel = 0;
    logic [7:0] adr = 0;
    logic [31:0] dat_i = 0;
    logic ack;
    logic [31:0] dat_o;
    logic [CH-1:0] la_load = 0;
    logic [W-1:0] la_data = 0;
    logic [CH*W-1:0] count;
    logic irq;

    wb_counter_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .reset(reset), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_sel(sel),
        .wb_adr(adr), .wb_dat_i(dat_i), .wb_ack(ack), .wb_dat_o(dat_o),
        .la_load(la_load), .la_data(la_data), .count(count), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int unsigned m_cnt[CH], m_rld[CH];
    bit m_en[CH], m_dn[CH], m_per[CH], m_ie[CH], m_match[CH];
    bit m_ack = 0, m_irq = 0;
    int unsigned m_presc = 0, m_div = 0;
    typedef struct {bit rd; logic [31:0] dat;} exp_t;
    exp_t q[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int unsigned merge(int unsigned old, logic [3:0] s, logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r & MASK;
    endfunction

    function automatic logic [31:0] m_read(logic [7:0] a);
        int c, r;
        c = int'(a[7:4]);
        r = int'(a[3:2]);
        if (c == 15) return r == 0 ? m_presc : 0;
        if (c >= CH) return 0;
        if (r == 0) return 32'({m_ie[c], m_per[c], m_dn[c], m_en[c]});
        if (r == 1) return m_cnt[c];
        if (r == 2) return m_rld[c];
        return 32'(m_match[c]);
    endfunction

    task automatic model_step();
        bit acc, wr, stp, set;
        int c, r;
        acc = cyc && stb && !m_ack;
        wr = acc && we;
        c = int'(adr[7:4]);
        r = int'(adr[3:2]);
        stp = 1;
`ifdef COUNTER_BANK_PRESCALER_EN
        stp = m_div == m_presc;
`endif
        if (reset) begin
            for (int n = 0; n < CH; n++) begin
                m_cnt[n] = 0; m_rld[n] = 0; m_en[n] = 0; m_dn[n] = 0;
                m_per[n] = 0; m_ie[n] = 0; m_match[n] = 0;
            end
            m_ack = 0; m_irq = 0; m_presc = 0; m_div = 0;
            q.delete();
            return;
        end
        if (acc) q.push_back('{rd: !we, dat: m_read(adr)});
        for (int n = 0; n < CH; n++) begin
            int unsigned target;
            set = 0;
            target = m_dn[n] ? 0 : m_rld[n];
            if (wr && c == n && r == 1) m_cnt[n] = merge(m_cnt[n], sel, dat_i);
            else if (la_load[n]) m_cnt[n] = la_data;
            else if (m_en[n] && stp) begin
                if (m_cnt[n] != target) m_cnt[n] = (m_dn[n] ? m_cnt[n] - 1 : m_cnt[n] + 1) & MASK;
                else begin
                    set = 1;
                    if (m_per[n]) m_cnt[n] = m_dn[n] ? m_rld[n] : 0;
                    else m_en[n] = 0;
                end
            end
            if (wr && c == n && r == 0 && sel[0]) {m_ie[n], m_per[n], m_dn[n], m_en[n]} = dat_i[3:0];
            if (wr && c == n && r == 2) m_rld[n] = merge(m_rld[n], sel, dat_i);
            if (set) m_match[n] = 1;
            else if (wr && c == n && r == 3 && sel[0] && dat_i[0]) m_match[n] = 0;
        end
`ifdef COUNTER_BANK_PRESCALER_EN
        if (wr && c == 15 && r == 0) begin
            if (sel[0]) m_presc = int'(dat_i[7:0]);
            m_div = 0;
        end else m_div = stp ? 0 : m_div + 1;
`endif
        m_irq = 0;
        for (int n = 0; n < CH; n++) m_irq |= m_match[n] & m_ie[n];
        m_ack = acc;
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("ack", 32'(ack), 32'(m_ack));
        if (m_ack && q.size() > 0) begin
            e = q.pop_front();
            if (e.rd) chk("rdata", dat_o, e.dat);
        end
        for (int n = 0; n < CH; n++) chk($sformatf("count%0d", n), 32'(count[n*W +: W]), m_cnt[n]);
        chk("irq", 32'(irq), 32'(m_irq));
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic xfer(bit w, logic [7:0] a, logic [3:0] s, logic [31:0] d, bit hold = 0);
        cyc = 1; stb = 1; we = w; adr = a; sel = s; dat_i = d;
        tick();
        if (hold) tick();
        cyc = 0; stb = 0; we = 0;
        tick();
    endtask

    initial begin
        logic [7:0] a;
        int c;
        repeat (3) tick();
        reset = 0;
        tick();
        chk("reset_count", 32'(count), 32'h0);
        for (int r = 0; r < 4; r++) xfer(0, 8'(r * 4), 4'hF, 0);

        // ch1 up/periodic with irq
        xfer(1, 8'h18, 4'hF, 5);
        xfer(1, 8'h10, 4'hF, 32'hD);
        repeat (14) tick();
        xfer(1, 8'h1C, 4'h1, 1, 1);
        repeat (3) tick();
        xfer(1, 8'h10, 4'hF, 0);
        xfer(1, 8'h1C, 4'h1, 1);
        chk("irq_cleared", 32'(irq), 32'h0);

        // ch2 down one-shot
        xfer(1, 8'h24, 4'hF, 3);
        xfer(1, 8'h20, 4'hF, 32'h3);
        repeat (6) tick();
        chk("oneshot_hold", 32'(count[2*W +: W]), 32'h0);
        xfer(0, 8'h20, 4'hF, 0);
        xfer(0, 8'h2C, 4'hF, 0);

        // ch0 COUNT write colliding with LA load
        xfer(1, 8'h08, 4'hF, 32'hFFFF);
        xfer(1, 8'h00, 4'hF, 32'h1);
        cyc = 1; stb = 1; we = 1; adr = 8'h04; sel = 4'hF; dat_i = 32'h1234;
        la_load = 4'b0001; la_data = 16'h00FF;
        tick();
        cyc = 0; stb = 0; we = 0; la_load = 0;
        chk("wb_over_la", 32'(count[W-1:0]), 32'h1234);
        tick();
        chk("wb_over_la_next", 32'(count[W-1:0]), 32'h1235);

        // ch3 byte-lane write
        xfer(1, 8'h34, 4'hF, 32'h11);
        xfer(1, 8'h34, 4'b0010, 32'h0000AB00);
        chk("byte_write", 32'(count[3*W +: W]), 32'hAB11);

        // global prescaler register (reads 0 when the feature is absent)
        xfer(1, 8'hF0, 4'h1, 3);
        repeat (12) tick();
        xfer(0, 8'hF0, 4'hF, 0);
        xfer(0, 8'h04, 4'hF, 0);
        xfer(1, 8'hF0, 4'h1, 0);

        repeat (1500) begin
            if ($urandom_range(0, 2) == 0) begin
                la_load = 4'($urandom) & 4'($urandom) & 4'($urandom);
                la_data = 16'($urandom);
                tick();
                la_load = 0;
            end else begin
                c = $urandom_range(0, 5);
                a = {c == 5 ? 4'hF : 4'(c), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                if (c == 5 && $urandom_range(0, 3) != 0) a = 8'h00;
                xfer(1'($urandom), a, 4'($urandom),
                     $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : $urandom, 1'($urandom));
            end
        end
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
